// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   pc_sel_e : next-PC select encodings driven by the control unit
//   state_e  : fetch FSM states (ERR exists only with INST_FETCH_MISALIGN_EN)
//   NOP      : addi x0,x0,0, shown in the instruction register until a fetch lands
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    PC_INC     = 2'b00,
    PC_TARGET  = 2'b01,
    PC_HOLD    = 2'b10,
    PC_INC_ALT = 2'b11
  } pc_sel_e;

`ifdef INST_FETCH_MISALIGN_EN
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    ERR  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_e;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next program-counter computation (purely combinational).
//   pc_i      : current pc
//   pc_sel_i  : 00 pc+4, 01 target, 10 hold, 11 pc+4
//   target_i  : jump/branch target byte address
//   pc_next_o : selected next pc (pc+4 wraps modulo 2^32)
module pc_next
  import inst_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i + 32'd4;
    case (pc_sel_e'(pc_sel_i))
      PC_TARGET: pc_next_o = target_i;
      PC_HOLD:   pc_next_o = pc_i;
      default:   pc_next_o = pc_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: BOOT -> REQ -> EXEC loop with one outstanding
// instruction-memory read at a time.
//   clk, rst            : clock; asynchronous active-low reset
//   pc_sel, target      : next-PC select and jump/branch target from control
//   imem_addr/req       : memory request (held until imem_valid)
//   imem_rdata/valid    : memory response, honoured only in REQ
//   pc, inst            : current instruction address and word
//   opcode..rs2         : decode field slices of inst
//   inst_valid          : inst is valid for decode (EXEC)
//   misalign            : sticky misaligned-target flag
// Build option INST_FETCH_MISALIGN_EN: a misaligned jump target traps into ERR
// (no requests, no valid instruction) until reset. Without it the low two
// target bits are dropped and misalign stays 0.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        inst_valid,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] target_eff;
  logic [31:0] pc_nxt;

`ifdef INST_FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic tgt_bad;

  assign target_eff = target;
  assign tgt_bad    = (pc_sel == PC_TARGET) && (target[1:0] != 2'b00);
  assign misalign   = misalign_q;
`else
  // Masking rather than slicing keeps every target bit in use.
  assign target_eff = target & 32'hFFFF_FFFC;
  assign misalign   = 1'b0;
`endif

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .pc_sel_i  (pc_sel),
    .target_i  (target_eff),
    .pc_next_o (pc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef INST_FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef INST_FETCH_MISALIGN_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      BOOT: begin
        state_d = REQ;
        pc_d    = RESET_PC;
      end
      REQ: begin
        if (imem_valid) begin
          inst_d  = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (pc_sel != PC_HOLD) begin
`ifdef INST_FETCH_MISALIGN_EN
          if (tgt_bad) begin
            misalign_d = 1'b1;
            state_d    = ERR;
          end else begin
            pc_d    = pc_nxt;
            state_d = REQ;
          end
`else
          pc_d    = pc_nxt;
          state_d = REQ;
`endif
        end
      end
`ifdef INST_FETCH_MISALIGN_EN
      ERR: begin
        state_d = ERR;
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  // Outputs depend only on registered state so reset takes effect at once.
  assign imem_req   = (state_q == REQ);
  assign inst_valid = (state_q == EXEC);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[6:2];
  assign func3      = inst_q[14:12];
  assign func7      = inst_q[31:25];
  assign rd         = inst_q[11:7];
  assign rs1        = inst_q[19:15];
  assign rs2        = inst_q[24:20];

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the stimulus process queues the expected
// request address and {pc,inst} for each fetch; a monitor on the falling edge
// pops and compares when a new request or a new valid instruction appears, and
// checks that address/pc/inst stay stable while a request or instruction is held.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  pc_sel;
  logic [31:0] target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        inst_valid;
  logic        misalign;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .target     (target),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .inst       (inst),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .inst_valid (inst_valid),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_exec_q[$];

  logic        prev_req  = 1'b0;
  logic        prev_val  = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_inst = '0;
  logic [63:0] exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares DUT presentations against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
        prev_val = 1'b0;
      end else begin
        if (imem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) fail_now("unexpected_req");
          else chk("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (imem_req && prev_req) chk("req_addr_stable", imem_addr, prev_addr);
        if (inst_valid && !prev_val) begin
          if (exp_exec_q.size() == 0) fail_now("unexpected_inst_valid");
          else begin
            exp_e = exp_exec_q.pop_front();
            chk("exec_pc", pc, exp_e[63:32]);
            chk("exec_inst", inst, exp_e[31:0]);
          end
        end
        if (inst_valid && prev_val) begin
          chk("hold_pc_stable", pc, prev_pc);
          chk("hold_inst_stable", inst, prev_inst);
        end
        prev_req  = imem_req;
        prev_val  = inst_valid;
        prev_addr = imem_addr;
        prev_pc   = pc;
        prev_inst = inst;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_imem_req"},   32'(imem_req),   32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_imem_addr"},  imem_addr,       32'h0);
    chk({tag, "_pc"},         pc,              32'h0);
    chk({tag, "_inst"},       inst,            32'h0000_0013);
    chk({tag, "_misalign"},   32'(misalign),   32'd0);
  endtask

  // Release reset with a stale imem_valid present during BOOT.
  task automatic release_boot();
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("boot_no_req", 32'(imem_req), 32'd0);
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    chk("boot_ignore_inst", inst, 32'h0000_0013);
    chk("boot_then_req", 32'(imem_req), 32'd1);
  endtask

  task automatic fetch(input int wait_cyc, input logic [31:0] addr, input logic [31:0] word);
    int n;
    exp_addr_q.push_back(addr);
    exp_exec_q.push_back({addr, word});
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    if (!imem_req) fail_now("fetch_req_timeout");
    for (int i = 0; i < wait_cyc; i++) begin
      chk("req_held", 32'(imem_req), 32'd1);
      tick();
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    chk("exec_entry", 32'(inst_valid), 32'd1);
  endtask

  task automatic exec_step(input logic [1:0] sel, input logic [31:0] tgt);
    pc_sel = sel;
    target = tgt;
    tick();
    pc_sel = PC_HOLD;
    target = '0;
  endtask

  initial begin
    pc_sel     = PC_HOLD;
    target     = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    #23;
    reset_checks("por");
    @(posedge clk);
    #2;
    release_boot();

    // Back-to-back fetches at 0, 4, 8.
    fetch(0, 32'h0000_0000, 32'h0050_0093);
    exec_step(2'b00, '0);
    fetch(0, 32'h0000_0004, 32'h0010_8113);
    exec_step(2'b00, '0);
    fetch(0, 32'h0000_0008, 32'h0000_A183);   // lw x3,0(x1)
    chk("load_opcode", 32'(opcode), 32'd0);
    chk("load_func3",  32'(func3),  32'd2);
    chk("load_rd",     32'(rd),     32'd3);
    chk("load_rs1",    32'(rs1),    32'd1);

    // Load phase: hold two cycles.
    pc_sel = PC_HOLD;
    tick();
    tick();
    chk("hold_still_valid", 32'(inst_valid), 32'd1);
    chk("hold_pc", pc, 32'h0000_0008);
    exec_step(2'b00, '0);
    fetch(0, 32'h0000_000C, 32'h4020_81B3);   // sub x3,x1,x2
    chk("sub_opcode", 32'(opcode), 32'h0C);
    chk("sub_func7",  32'(func7),  32'h20);
    chk("sub_rs2",    32'(rs2),    32'd2);

    // Jump, then wrap from the top of the address space via pc_sel=11.
    exec_step(2'b01, 32'h0000_0100);
    fetch(0, 32'h0000_0100, 32'h0640_0213);
    exec_step(2'b01, 32'hFFFF_FFFC);
    fetch(0, 32'hFFFF_FFFC, 32'h1111_1111);
    exec_step(2'b11, '0);
    fetch(0, 32'h0000_0000, 32'h2222_2222);

    // Slow memory, then a stray strobe while executing.
    exec_step(2'b00, '0);
    fetch(3, 32'h0000_0004, 32'h3333_3333);
    pc_sel     = PC_HOLD;
    imem_valid = 1'b1;
    imem_rdata = 32'hBADB_AD00;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    tick();
    tick();
    chk("stray_valid_inst", inst, 32'h3333_3333);

    // Reset in the middle of a request.
    exec_step(2'b00, '0);
    chk("midreq_req_before", 32'(imem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    reset_checks("midreq");
    @(posedge clk);
    #2;
    release_boot();
    fetch(0, 32'h0000_0000, 32'h0050_0093);

    // Misaligned jump target.
    exec_step(2'b01, 32'h0000_0102);
`ifdef INST_FETCH_MISALIGN_EN
    for (int i = 0; i < 3; i++) begin
      chk("err_misalign",   32'(misalign),   32'd1);
      chk("err_imem_req",   32'(imem_req),   32'd0);
      chk("err_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("err_reset_misalign", 32'(misalign), 32'd0);
`else
    fetch(0, 32'h0000_0100, 32'h0070_0293);
    chk("no_misalign", 32'(misalign), 32'd0);
`endif

    tick();
    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("exec_queue_drained", 32'(exp_exec_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port pc_sel  input  2  next-PC select from ctrl: 00 pc+4, 01 target, 10 hold (load phase), 11 treated as 00.
REQ-005 SHALL have port target  input  32  jump/branch target byte address.
REQ-006 SHALL have port imem_addr  output  32  instruction memory byte address.
REQ-007 SHALL have port imem_req  output  1  read request, held until accepted.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-009 SHALL have port imem_valid  input  1  read-data strobe, one cycle per request.
REQ-010 SHALL have port pc  output  32  address of the instruction in inst.
REQ-011 SHALL have port inst  output  32  instruction register.
REQ-012 SHALL have ports opcode (5, inst[6:2]), func3 (3, inst[14:12]), func7 (7, inst[31:25]), rd (5), rs1 (5), rs2 (5), all outputs, all combinational slices of inst.
REQ-013 SHALL have port inst_valid  output  1  inst is valid for decode this cycle.
REQ-014 SHALL have port misalign  output  1  sticky misaligned-target flag (INST_FETCH_MISALIGN_EN only; tied 0 otherwise).

Function
REQ-015 SHALL implement the FSM states BOOT, REQ, EXEC, and ERR (ERR present only with the macro).
REQ-016 BOOT SHALL last exactly one cycle after reset release, then go to REQ with pc=RESET_PC.
REQ-017 In REQ: imem_req=1 and imem_addr=pc; on imem_valid=1, inst<=imem_rdata at that edge, then go to EXEC; inst_valid=0 throughout REQ.
REQ-018 In EXEC: inst_valid=1; pc_sel=10 keeps the FSM in EXEC with pc/inst unchanged; any other pc_sel updates pc and goes to REQ at the next edge.
REQ-019 Next pc SHALL be pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) for 00/11, and target for 01.
REQ-020 Fetch latency SHALL be 1 cycle REQ (when imem_valid returns same cycle) plus 1 cycle EXEC per instruction; each extra imem_valid wait cycle adds one.
REQ-021 imem_valid outside REQ SHALL be ignored; inst SHALL NOT change outside REQ.
REQ-022 inst SHALL be 32'h0000_0013 (NOP) whenever not yet loaded since reset.

Reset
REQ-023 rst=0 SHALL asynchronously force: state=BOOT, pc=RESET_PC, inst=32'h13, inst_valid=0, imem_req=0, imem_addr=RESET_PC, misalign=0.
REQ-024 Reset asserted mid-request SHALL abandon the request; a late imem_valid after release, while in BOOT, SHALL be ignored.

Configuration
REQ-025 Macro INST_FETCH_MISALIGN_EN defined: target[1:0]!=0 with pc_sel=01 in EXEC SHALL set misalign=1, enter ERR, hold imem_req=0 and inst_valid=0 until reset.
REQ-026 Macro undefined: target[1:0] SHALL be forced to 00, no ERR state, misalign tied 0.

Structure
REQ-027 A shared package SHALL hold pc_sel encodings (PC_INC, PC_TARGET, PC_HOLD), the FSM state enum, and the NOP constant 32'h13.
REQ-028 One sub-module, pc_next, SHALL compute the next pc combinationally from pc, pc_sel, and target.

Verification
REQ-029 Reset release with RESET_PC=0 and imem_valid returned in the same cycle SHALL produce imem_addr 0, 4, 8 on successive REQ cycles, with inst_valid toggling 0,1,0,1.
REQ-030 In EXEC with opcode LOAD (5'b00000) and pc_sel=10 for 2 cycles, then 00, SHALL keep pc and inst stable for 2 cycles, then show the next fetch at pc+4.
REQ-031 pc_sel=01 with target=32'h0000_0100 SHALL make the next imem_addr 32'h100; pc=32'hFFFF_FFFC with pc_sel=00 SHALL make the next imem_addr 0.
REQ-032 imem_valid delayed 3 cycles SHALL hold imem_req=1 and imem_addr stable for 3 cycles, and a stray imem_valid in EXEC SHALL leave inst unchanged.
REQ-033 With the macro, target=32'h102 with pc_sel=01 SHALL give misalign=1 and imem_req=0 until reset; without the macro, the same stimulus SHALL fetch 32'h100.
REQ-034 rst=0 asserted mid-REQ SHALL produce outputs matching REQ-023 immediately (before the next clock edge).
